pc_return_stack: RTL and testbench

- Return-address stack that feeds the program counter's load path.
- On a subroutine call, the control unit pushes the return address.
- On a return, the block pops that address and presents it on RET_ADDR, with a one-cycle RET_LD strobe that drives the PC's LD/DIN inputs directly.
- Sits between the control unit and the program counter, alongside the next-PC mux.

---
 rtl/pc_return_stack.sv | 136 +++++++++++++
 tb/tb_pc_return_stack.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_return_stack.sv
// pc_return_stack: return-address stack feeding the program counter load path.
// A call pushes the return address. A return pops it onto o_ret_addr and
// pulses o_ret_ld for one cycle, which drives the PC's LD/DIN inputs directly.
// Latency from pop to o_ret_ld is one cycle.
module pc_return_stack #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic          i_pop,
    input  logic          i_clr_err,
    output logic [AW-1:0] o_ret_addr,
    output logic          o_ret_ld,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_ovf,
    output logic          o_unf
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage is deliberately left without a reset; entries above the count are don't-care.
    logic [AW-1:0] r_mem [DEPTH];

    logic [CW-1:0] r_count;
    logic [AW-1:0] r_ret_addr;
    logic          r_ret_ld;
    logic          r_ovf;
    logic          r_unf;

    logic          w_empty;
    logic          w_full;
    logic          w_push_only;
    logic          w_pop_only;
    logic          w_swap;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_ovf_set;
    logic          w_unf_set;
    logic [IW-1:0] w_top_idx;
    logic [IW-1:0] w_wr_idx;
    logic          w_wr_en;
    logic [CW-1:0] w_count_nxt;

    // Occupancy status taken straight from the count.
    always_comb begin
        w_empty = (r_count == CW'(0));
        w_full  = (r_count == CW'(DEPTH));
    end

    // Classify this cycle's request. A push+pop on an empty stack acts as a plain push.
    always_comb begin
        w_push_only = i_push & (~i_pop | w_empty);
        w_pop_only  = i_pop & ~i_push;
        w_swap      = i_push & i_pop & ~w_empty;

        w_push_ok   = w_push_only & ~w_full;
        w_ovf_set   = w_push_only & w_full;
        w_pop_ok    = i_pop & ~w_empty;
        w_unf_set   = w_pop_only & w_empty;
    end

    // Write address: next free slot on push, top slot on a tail-call swap.
    always_comb begin
        w_top_idx = IW'(r_count - CW'(1));
        w_wr_en   = w_push_ok | w_swap;
        w_wr_idx  = w_swap ? w_top_idx : IW'(r_count);
    end

    // Next count: a swap leaves it unchanged; saturation comes from the ok qualifiers.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop_ok && !w_swap) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Stack storage write port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= i_push_addr;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Return address capture plus one-cycle load strobe toward the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ret_addr <= '0;
            r_ret_ld   <= 1'b0;
        end else begin
            r_ret_ld <= w_pop_ok;
            if (w_pop_ok) begin
                r_ret_addr <= r_mem[w_top_idx];
            end
        end
    end

    // Sticky error flags. A new error in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~i_clr_err);
            r_unf <= w_unf_set | (r_unf & ~i_clr_err);
        end
    end

    // Output mapping. Empty and full are decoded from the registered count.
    always_comb begin
        o_ret_addr = r_ret_addr;
        o_ret_ld   = r_ret_ld;
        o_count    = r_count;
        o_empty    = w_empty;
        o_full     = w_full;
        o_ovf      = r_ovf;
        o_unf      = r_unf;
    end

endmodule

// File: tb/tb_pc_return_stack.sv
// Self-checking bench for pc_return_stack: directed scenarios plus randomized traffic against a queue model.
module tb_pc_return_stack;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_push = 1'b0;
    logic [AW-1:0] i_push_addr = '0;
    logic          i_pop = 1'b0;
    logic          i_clr_err = 1'b0;
    logic [AW-1:0] o_ret_addr;
    logic          o_ret_ld;
    logic [CW-1:0] o_count;
    logic          o_empty;
    logic          o_full;
    logic          o_ovf;
    logic          o_unf;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [AW-1:0] m_q[$];
    logic [AW-1:0] m_ret = '0;
    logic          m_ld  = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    pc_return_stack #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (i_push),
        .i_push_addr (i_push_addr),
        .i_pop       (i_pop),
        .i_clr_err   (i_clr_err),
        .o_ret_addr  (o_ret_addr),
        .o_ret_ld    (o_ret_ld),
        .o_count     (o_count),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_ovf       (o_ovf),
        .o_unf       (o_unf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_ret = '0;
        m_ld  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Apply one cycle of stimulus, advance the model, leave the bench at edge+1.
    task automatic drive(input logic push, input logic [AW-1:0] addr,
                         input logic pop, input logic clr);
        logic e_ovf;
        logic e_unf;
        i_push      = push;
        i_push_addr = addr;
        i_pop       = pop;
        i_clr_err   = clr;
        @(posedge clk);
        #1;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        m_ld  = 1'b0;
        if (push && pop && m_q.size() > 0) begin
            m_ret = m_q[m_q.size()-1];
            m_q[m_q.size()-1] = addr;
            m_ld = 1'b1;
        end else if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(addr);
            else e_ovf = 1'b1;
        end else if (pop) begin
            if (m_q.size() > 0) begin
                m_ret = m_q.pop_back();
                m_ld  = 1'b1;
            end else begin
                e_unf = 1'b1;
            end
        end
        m_ovf = e_ovf | (m_ovf & ~clr);
        m_unf = e_unf | (m_unf & ~clr);
        i_push    = 1'b0;
        i_pop     = 1'b0;
        i_clr_err = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 10'h155, 1'b0, 1'b0);
        drive(1'b1, 10'h2AB, 1'b0, 1'b0);
        drive(1'b0, 10'h000, 1'b1, 1'b0);
        drive(1'b0, 10'h000, 1'b1, 1'b1);
        drive(1'b0, 10'h000, 1'b1, 1'b0);
        // Mid-cycle reset with a push pending must clear everything at once.
        #2;
        i_push = 1'b1;
        i_push_addr = 10'h3C3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (o_count !== 4'd0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_ret_addr !== 10'h000
            || o_ret_ld !== 1'b0 || o_ovf !== 1'b0 || o_unf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: cnt=%0d emp=%b full=%b ret=%h ld=%b ovf=%b unf=%b, required 0 1 0 000 0 0 0",
                     o_count, o_empty, o_full, o_ret_addr, o_ret_ld, o_ovf, o_unf);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (o_count !== 4'd0 || o_ret_ld !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: cnt=%0d ld=%b, required 0 0", o_count, o_ret_ld);
        end
        i_push = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_lifo();
        logic [AW-1:0] vals [3];
        vals[0] = 10'h010;
        vals[1] = 10'h020;
        vals[2] = 10'h3FF;
        for (int i = 0; i < 3; i++) drive(1'b1, vals[i], 1'b0, 1'b0);
        n_vec++;
        if (o_count !== 4'd3) begin
            n_err++;
            $display("FAIL lifo_count: got %0d, required 3", o_count);
        end
        for (int i = 2; i >= 0; i--) begin
            drive(1'b0, 10'h000, 1'b1, 1'b0);
            n_vec++;
            if (o_ret_addr !== vals[i] || o_ret_ld !== 1'b1) begin
                n_err++;
                $display("FAIL lifo_pop%0d: ret=%h ld=%b, required %h 1", 2 - i, o_ret_addr, o_ret_ld, vals[i]);
            end
        end
        n_vec++;
        if (o_empty !== 1'b1) begin
            n_err++;
            $display("FAIL lifo_empty: got %b, required 1", o_empty);
        end
        drive(1'b0, 10'h000, 1'b0, 1'b0);
        n_vec++;
        if (o_ret_ld !== 1'b0 || o_ret_addr !== 10'h010) begin
            n_err++;
            $display("FAIL lifo_hold: ret=%h ld=%b, required 010 0", o_ret_addr, o_ret_ld);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) drive(1'b1, AW'(i), 1'b0, 1'b0);
        n_vec++;
        if (o_full !== 1'b1 || o_count !== 4'd8 || o_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_full: full=%b cnt=%0d ovf=%b, required 1 8 0", o_full, o_count, o_ovf);
        end
        drive(1'b1, 10'h155, 1'b0, 1'b0);
        n_vec++;
        if (o_count !== 4'd8 || o_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: cnt=%0d ovf=%b, required 8 1", o_count, o_ovf);
        end
        drive(1'b0, 10'h000, 1'b1, 1'b0);
        n_vec++;
        if (o_ret_addr !== 10'h008 || o_ret_ld !== 1'b1 || o_full !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_pop: ret=%h ld=%b full=%b, required 008 1 0", o_ret_addr, o_ret_ld, o_full);
        end
        for (int i = 7; i >= 1; i--) begin
            drive(1'b0, 10'h000, 1'b1, 1'b0);
            n_vec++;
            if (o_ret_addr !== AW'(i) || o_ovf !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_drain%0d: ret=%h ovf=%b, required %h 1", i, o_ret_addr, o_ovf, AW'(i));
            end
        end
        drive(1'b0, 10'h000, 1'b0, 1'b1);
        n_vec++;
        if (o_ovf !== 1'b0 || o_empty !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_clear: ovf=%b emp=%b, required 0 1", o_ovf, o_empty);
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, 10'h000, 1'b1, 1'b0);
        n_vec++;
        if (o_unf !== 1'b1 || o_ret_ld !== 1'b0 || o_ret_addr !== 10'h001 || o_count !== 4'd0) begin
            n_err++;
            $display("FAIL unf_set: unf=%b ld=%b ret=%h cnt=%0d, required 1 0 001 0",
                     o_unf, o_ret_ld, o_ret_addr, o_count);
        end
        drive(1'b0, 10'h000, 1'b1, 1'b1);
        n_vec++;
        if (o_unf !== 1'b1) begin
            n_err++;
            $display("FAIL unf_clr_race: unf=%b, required 1", o_unf);
        end
        drive(1'b0, 10'h000, 1'b0, 1'b1);
        n_vec++;
        if (o_unf !== 1'b0) begin
            n_err++;
            $display("FAIL unf_clear: unf=%b, required 0", o_unf);
        end
    endtask

    task automatic test_swap();
        drive(1'b1, 10'h100, 1'b0, 1'b0);
        drive(1'b1, 10'h200, 1'b0, 1'b0);
        drive(1'b1, 10'h2AA, 1'b1, 1'b0);
        n_vec++;
        if (o_ret_addr !== 10'h200 || o_ret_ld !== 1'b1 || o_count !== 4'd2 || o_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL swap: ret=%h ld=%b cnt=%0d ovf=%b, required 200 1 2 0",
                     o_ret_addr, o_ret_ld, o_count, o_ovf);
        end
        drive(1'b0, 10'h000, 1'b1, 1'b0);
        n_vec++;
        if (o_ret_addr !== 10'h2AA || o_ret_ld !== 1'b1) begin
            n_err++;
            $display("FAIL swap_pop: ret=%h ld=%b, required 2AA 1", o_ret_addr, o_ret_ld);
        end
        drive(1'b0, 10'h000, 1'b1, 1'b0);
        n_vec++;
        if (o_ret_addr !== 10'h100 || o_empty !== 1'b1) begin
            n_err++;
            $display("FAIL swap_pop2: ret=%h emp=%b, required 100 1", o_ret_addr, o_empty);
        end
        drive(1'b1, 10'h077, 1'b1, 1'b0);
        n_vec++;
        if (o_count !== 4'd1 || o_ret_ld !== 1'b0 || o_unf !== 1'b0 || o_ret_addr !== 10'h100) begin
            n_err++;
            $display("FAIL swap_empty: cnt=%0d ld=%b unf=%b ret=%h, required 1 0 0 100",
                     o_count, o_ret_ld, o_unf, o_ret_addr);
        end
        drive(1'b0, 10'h000, 1'b1, 1'b0);
        n_vec++;
        if (o_ret_addr !== 10'h077 || o_ret_ld !== 1'b1) begin
            n_err++;
            $display("FAIL swap_empty_pop: ret=%h ld=%b, required 077 1", o_ret_addr, o_ret_ld);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, AW'(10'h0A0 + i), 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (o_count !== 4'd0 || o_ret_addr !== 10'h000) begin
            n_err++;
            $display("FAIL rst_mid_hold: cnt=%0d ret=%h, required 0 000", o_count, o_ret_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (o_count !== 4'd0 || o_empty !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_release: cnt=%0d emp=%b, required 0 1", o_count, o_empty);
        end
        drive(1'b0, 10'h000, 1'b1, 1'b0);
        n_vec++;
        if (o_unf !== 1'b1 || o_ret_ld !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_pop: unf=%b ld=%b, required 1 0", o_unf, o_ret_ld);
        end
        drive(1'b0, 10'h000, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic          push;
        logic          pop;
        logic          clr;
        logic [AW-1:0] addr;
        for (int n = 0; n < 600; n++) begin
            push = ($urandom_range(0, 99) < 50);
            pop  = ($urandom_range(0, 99) < 45);
            clr  = ($urandom_range(0, 99) < 8);
            addr = AW'($urandom);
            drive(push, addr, pop, clr);
            n_vec++;
            if (o_count !== CW'(m_q.size()) || o_empty !== (m_q.size() == 0)
                || o_full !== (m_q.size() == DEPTH)) begin
                n_err++;
                $display("FAIL rand_count[%0d]: cnt=%0d emp=%b full=%b, required cnt %0d",
                         n, o_count, o_empty, o_full, m_q.size());
            end
            n_vec++;
            if (o_ret_addr !== m_ret || o_ret_ld !== m_ld) begin
                n_err++;
                $display("FAIL rand_ret[%0d]: ret=%h ld=%b, required %h %b", n, o_ret_addr, o_ret_ld, m_ret, m_ld);
            end
            n_vec++;
            if (o_ovf !== m_ovf || o_unf !== m_unf) begin
                n_err++;
                $display("FAIL rand_flags[%0d]: ovf=%b unf=%b, required %b %b", n, o_ovf, o_unf, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_swap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
